// File: rtl/black_level_restorer_pkg.sv
// Shared types and widths for the black-level restorer.
// Holds the FSM state enum and the saturating helper.
package black_level_restorer_pkg;

  localparam int PIX_W  = 8;
  localparam int DIFF_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DELAY   = 2'd1,
    ST_MEASURE = 2'd2,
    ST_ACTIVE  = 2'd3
  } state_e;

  localparam logic signed [DIFF_W-1:0] S_MAX =
    DIFF_W'(127);
  localparam logic signed [DIFF_W-1:0] S_MIN =
    -DIFF_W'(128);

  function automatic logic [PIX_W-1:0] sat8(
    input logic signed [DIFF_W-1:0] d
  );
    logic [PIX_W-1:0] r;
    if (d > S_MAX) begin
      r = 8'h7F;
    end else if (d < S_MIN) begin
      r = 8'h80;
    end else begin
      r = d[PIX_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/black_level_restorer_if.sv
// Video sample bus for the black-level restorer.
// master drives sync and samples, slave returns the result.
interface black_level_restorer_if;
  import black_level_restorer_pkg::*;

  logic             hsync;
  logic             pix_valid;
  logic [PIX_W-1:0] pix_in;
  logic             out_valid;
  logic [PIX_W-1:0] pix_out;
  logic [PIX_W-1:0] level;

  modport master (
    output hsync,
    output pix_valid,
    output pix_in,
    input  out_valid,
    input  pix_out,
    input  level
  );

  modport slave (
    input  hsync,
    input  pix_valid,
    input  pix_in,
    output out_valid,
    output pix_out,
    output level
  );

endinterface

// File: rtl/black_level_restorer_sat_sub.sv
// Unsigned minus unsigned, saturated to 8-bit signed.
// Purely combinational.
module sat_sub
  import black_level_restorer_pkg::*;
(
  input  logic [PIX_W-1:0] a_i,
  input  logic [PIX_W-1:0] b_i,
  output logic [PIX_W-1:0] y_o
);

  logic signed [DIFF_W-1:0] diff;

  always_comb begin
    diff = $signed({1'b0, a_i})
         - $signed({1'b0, b_i});
  end

  assign y_o = sat8(diff);

endmodule

// File: rtl/black_level_restorer.sv
// Measures the back-porch level after each hsync edge
// and subtracts it from every sample with saturation.
module black_level_restorer
  import black_level_restorer_pkg::*;
#(
  parameter int PORCH_DELAY = 8,
  parameter int MEAS_LOG2   = 4
) (
  input logic                   m_clock,
  input logic                   mreset_n,
  black_level_restorer_if.slave bus
);

  localparam int ACC_W = PIX_W + MEAS_LOG2;
  localparam int CNT_W = MEAS_LOG2 + 1;

  localparam logic [CNT_W-1:0] MEAS_N =
    CNT_W'(1 << MEAS_LOG2);
  localparam logic [8:0] PORCH =
    9'(PORCH_DELAY);

  state_e           state_q, state_d;
  logic             hs_q, hs_d;
  logic [7:0]       dly_q, dly_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [PIX_W-1:0] level_q, level_d;
  logic [PIX_W-1:0] pix_out_q, pix_out_d;
  logic             out_valid_q, out_valid_d;

  logic             line_start;
  logic [8:0]       dly_nxt;
  logic [CNT_W-1:0] mcnt_nxt;
  logic [ACC_W-1:0] acc_nxt;
  logic [PIX_W-1:0] sat_y;

  assign line_start = bus.hsync & ~hs_q;
  assign dly_nxt    = {1'b0, dly_q} + 9'd1;
  assign mcnt_nxt   = mcnt_q + CNT_W'(1);
  assign acc_nxt    = acc_q + ACC_W'(bus.pix_in);

  always_comb begin
    state_d = state_q;
    hs_d    = bus.hsync;
    dly_d   = dly_q;
    mcnt_d  = mcnt_q;
    acc_d   = acc_q;
    level_d = level_q;
    if (line_start) begin
      // a zero porch skips DELAY entirely
      state_d = (PORCH == 9'd0) ? ST_MEASURE
                                : ST_DELAY;
      dly_d   = '0;
      mcnt_d  = '0;
      acc_d   = '0;
    end else if (bus.pix_valid) begin
      unique case (state_q)
        ST_IDLE: begin
        end
        ST_DELAY: begin
          dly_d = dly_nxt[7:0];
          if (dly_nxt == PORCH) begin
            state_d = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          acc_d  = acc_nxt;
          mcnt_d = mcnt_nxt;
          if (mcnt_nxt == MEAS_N) begin
            level_d = acc_nxt[ACC_W-1:MEAS_LOG2];
            state_d = ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
        end
        default: begin
        end
      endcase
    end
  end

  sat_sub u_sat (
    .a_i (bus.pix_in),
    .b_i (level_q),
    .y_o (sat_y)
  );

  always_comb begin
    out_valid_d = bus.pix_valid;
    pix_out_d   = bus.pix_valid ? sat_y
                                : pix_out_q;
  end

  always_ff @(posedge m_clock or negedge mreset_n) begin
    if (!mreset_n) begin
      state_q     <= ST_IDLE;
      hs_q        <= 1'b0;
      dly_q       <= '0;
      mcnt_q      <= '0;
      acc_q       <= '0;
      level_q     <= '0;
      pix_out_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hs_q        <= hs_d;
      dly_q       <= dly_d;
      mcnt_q      <= mcnt_d;
      acc_q       <= acc_d;
      level_q     <= level_d;
      pix_out_q   <= pix_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.pix_out   = pix_out_q;
  assign bus.level     = level_q;

endmodule

// File: tb/tb_black_level_restorer.sv
// Scoreboard bench for black_level_restorer.
// Directed scenarios plus random lines against a line-level model.
module tb_black_level_restorer;
  import black_level_restorer_pkg::*;

  localparam int PD = 8;
  localparam int ML = 4;
  localparam int N  = 1 << ML;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  black_level_restorer_if bus ();

  black_level_restorer #(
    .PORCH_DELAY (PD),
    .MEAS_LOG2   (ML)
  ) dut (
    .m_clock  (clk),
    .mreset_n (rst_n),
    .bus      (bus)
  );

  typedef struct {
    logic       ov;
    logic [7:0] px;
    logic [7:0] lv;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // line-level model: porch samples to skip, then a window to average
  int m_level;
  int m_last;
  bit m_prev_hs;
  int m_phase;
  int m_skip;
  int m_samp[$];

  function automatic int sat(input int d);
    if (d > 127) return 127;
    if (d < -128) return -128;
    return d;
  endfunction

  task automatic chk(input string nm,
                     input logic [7:0] got,
                     input logic [7:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, got, want);
    end
  endtask

  task automatic model_reset();
    m_level   = 0;
    m_last    = 0;
    m_prev_hs = 1'b0;
    m_phase   = 0;
    m_skip    = 0;
    m_samp.delete();
  endtask

  task automatic cyc(input bit hs,
                     input bit v,
                     input bit [7:0] px);
    exp_t e;
    bit   ls;
    int   s;
    @(negedge clk);
    rst_n         = 1'b1;
    bus.hsync     = hs;
    bus.pix_valid = v;
    bus.pix_in    = px;
    e.ov = v;
    if (v) m_last = sat(int'(px) - m_level);
    e.px = m_last[7:0];
    ls = hs && !m_prev_hs;
    m_prev_hs = hs;
    if (ls) begin
      m_samp.delete();
      m_skip  = PD;
      m_phase = (PD == 0) ? 2 : 1;
    end else if (v) begin
      if (m_phase == 1) begin
        m_skip--;
        if (m_skip == 0) m_phase = 2;
      end else if (m_phase == 2) begin
        m_samp.push_back(int'(px));
        if (m_samp.size() == N) begin
          s = 0;
          foreach (m_samp[i]) s += m_samp[i];
          m_level = s / N;
          m_phase = 3;
        end
      end
    end
    e.lv = m_level[7:0];
    sb.push_back(e);
  endtask

  task automatic rst_cyc(input int n);
    exp_t e;
    repeat (n) begin
      @(negedge clk);
      rst_n         = 1'b0;
      bus.hsync     = 1'b0;
      bus.pix_valid = 1'b0;
      bus.pix_in    = 8'h00;
      model_reset();
      e.ov = 1'b0;
      e.px = 8'h00;
      e.lv = 8'h00;
      sb.push_back(e);
    end
  endtask

  task automatic peek();
    @(posedge clk);
    #2;
  endtask

  task automatic line_porch(input bit [7:0] px);
    cyc(1'b1, 1'b0, 8'h00);
    repeat (PD) cyc(1'b0, 1'b1, px);
  endtask

  task automatic meas(input bit [7:0] px,
                      input int n);
    repeat (n) cyc(1'b0, 1'b1, px);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_valid", {7'b0, bus.out_valid},
            {7'b0, e.ov});
        chk("pix_out", bus.pix_out, e.px);
        chk("level", bus.level, e.lv);
      end
    end
  end

  initial begin : driver
    int hs_left;
    bit hs;
    bus.hsync     = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_in    = 8'h00;
    model_reset();
    rst_cyc(3);

    cyc(1'b0, 1'b1, 8'h50);
    peek();
    chk("idle_pass", bus.pix_out, 8'h50);
    cyc(1'b0, 1'b1, 8'hC8);
    peek();
    chk("idle_clip", bus.pix_out, 8'h7F);

    line_porch(8'hFF);
    meas(8'h20, N);
    peek();
    chk("lvl_20", bus.level, 8'h20);
    cyc(1'b0, 1'b1, 8'h30);
    peek();
    chk("pos_diff", bus.pix_out, 8'h10);
    cyc(1'b0, 1'b1, 8'h10);
    peek();
    chk("neg_diff", bus.pix_out, 8'hF0);

    line_porch(8'h00);
    for (int i = 0; i < N; i++)
      cyc(1'b0, 1'b1, (i % 2) ? 8'h22 : 8'h21);
    peek();
    chk("lvl_trunc", bus.level, 8'h21);

    cyc(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < PD; i++) begin
      cyc(1'b0, 1'b1, 8'hAA);
      cyc(1'b0, 1'b0, 8'h55);
    end
    for (int i = 0; i < N; i++) begin
      cyc(1'b0, 1'b1, 8'h37);
      cyc(1'b0, 1'b0, 8'h00);
    end
    peek();
    chk("lvl_gapped", bus.level, 8'h37);

    line_porch(8'h00);
    meas(8'h99, N - 1);
    cyc(1'b1, 1'b1, 8'h99);
    peek();
    chk("ls_wins", bus.level, 8'h37);
    cyc(1'b1, 1'b1, 8'hFF);
    cyc(1'b1, 1'b1, 8'hFF);
    meas(8'hFF, PD - 2);
    meas(8'h77, N);
    peek();
    chk("hs_held", bus.level, 8'h77);

    line_porch(8'h00);
    meas(8'hF0, N);
    cyc(1'b0, 1'b1, 8'h00);
    peek();
    chk("sat_neg", bus.pix_out, 8'h80);
    rst_cyc(2);
    cyc(1'b0, 1'b1, 8'hFF);
    peek();
    chk("sat_pos", bus.pix_out, 8'h7F);

    line_porch(8'h00);
    meas(8'h40, N);
    line_porch(8'h00);
    meas(8'h90, 10);
    cyc(1'b1, 1'b0, 8'h00);
    peek();
    chk("abort_hs", bus.level, 8'h40);
    meas(8'h00, PD);
    meas(8'h90, N);
    peek();
    chk("remeasure", bus.level, 8'h90);
    line_porch(8'h00);
    meas(8'hA0, 10);
    rst_cyc(2);
    peek();
    chk("abort_rst", bus.level, 8'h00);
    line_porch(8'h00);
    meas(8'hA0, N);
    peek();
    chk("after_rst", bus.level, 8'hA0);

    hs_left = 0;
    repeat (4000) begin
      if (hs_left == 0 && $urandom_range(0, 59) == 0)
        hs_left = $urandom_range(1, 3);
      hs = (hs_left > 0);
      if (hs_left > 0) hs_left--;
      if ($urandom_range(0, 999) == 0)
        rst_cyc(1);
      else
        cyc(hs, $urandom_range(0, 3) != 0,
            8'($urandom));
    end

    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    peek();
    chk("sb_drain", 8'(sb.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
